// File: rtl/rf_write_checker_pkg.sv
// Shared definitions for the register-file write checker: FSM states and error codes.
package rf_write_checker_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StPass  = 2'd2,
        StFail  = 2'd3
    } state_e;

    localparam logic [1:0] ErrNone     = 2'b00;
    localparam logic [1:0] ErrMismatch = 2'b01;
    localparam logic [1:0] ErrTimeout  = 2'b10;

endpackage

// File: rtl/rf_write_checker_if.sv
// Expectation push channel, writeback snoop port and status outputs of the checker.
interface rf_write_checker_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned REG_W = 5,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic             exp_valid;
    logic             exp_ready;
    logic [REG_W-1:0] exp_reg;
    logic [XLEN-1:0]  exp_data;

    logic             wb_en;
    logic [REG_W-1:0] wb_reg;
    logic [XLEN-1:0]  wb_data;

    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic [1:0]       err_code;
    logic [CntW-1:0]  match_count;
    logic [REG_W-1:0] obs_reg;
    logic [XLEN-1:0]  obs_data;

    // Checker side
    modport slave (
        input  exp_valid, exp_reg, exp_data, wb_en, wb_reg, wb_data,
        output exp_ready, busy, done, pass, fail, err_code, match_count, obs_reg, obs_data
    );

    // Stimulus / CPU side
    modport master (
        output exp_valid, exp_reg, exp_data, wb_en, wb_reg, wb_data,
        input  exp_ready, busy, done, pass, fail, err_code, match_count, obs_reg, obs_data
    );

endinterface

// File: rtl/rf_write_checker_exp_fifo.sv
// Expectation queue: power-of-two deep synchronous FIFO with flush and first-word head output.
module rf_write_checker_exp_fifo #(
    parameter int unsigned Width = 37,
    parameter int unsigned Depth = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [Width-1:0]           wdata_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic [Width-1:0]           head_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Full pushes and empty pops are dropped; a flush overrides both.
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    // Pointer and occupancy next-state; pointers wrap naturally modulo Depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are only meaningful while counted, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/rf_write_checker.sv
// In-order checker of register-file writebacks against a queue of expected writes.
module rf_write_checker
    import rf_write_checker_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned SKIP_X0 = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               start_i,
    rf_write_checker_if.slave  bus
);
    localparam int unsigned CntW   = $clog2(DEPTH + 1);
    localparam int unsigned TimerW = $clog2(TIMEOUT);

    state_e           state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [CntW-1:0]  match_q, match_d;
    logic [1:0]       err_q, err_d;
    logic [REG_W-1:0] obs_reg_q, obs_reg_d;
    logic [XLEN-1:0]  obs_data_q, obs_data_d;

    logic             push, pop, full, empty, qualify, hit;
    logic [CntW-1:0]  count;
    logic [REG_W-1:0] head_reg;
    logic [XLEN-1:0]  head_data;

    rf_write_checker_exp_fifo #(
        .Width (REG_W + XLEN),
        .Depth (DEPTH)
    ) u_exp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (clr_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({bus.exp_reg, bus.exp_data}),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count),
        .head_o  ({head_reg, head_data})
    );

    assign qualify = bus.wb_en && ((SKIP_X0 == 0) || (bus.wb_reg != '0));
    assign hit     = (bus.wb_reg == head_reg) && (bus.wb_data == head_data);

    // FSM next-state, timer, match counter and mismatch capture; clr wins over everything.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        match_d    = match_q;
        err_d      = err_q;
        obs_reg_d  = obs_reg_q;
        obs_data_d = obs_data_q;
        push       = 1'b0;
        pop        = 1'b0;
        if (clr_i) begin
            state_d    = StIdle;
            timer_d    = '0;
            match_d    = '0;
            err_d      = ErrNone;
            obs_reg_d  = '0;
            obs_data_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    push = bus.exp_valid && !full;
                    if (start_i) begin
                        timer_d = '0;
                        match_d = '0;
                        state_d = empty ? StPass : StArmed;
                    end
                end
                StArmed: begin
                    if (qualify) begin
                        if (hit) begin
                            pop     = 1'b1;
                            match_d = match_q + CntW'(1);
                            timer_d = '0;
                            if (count == CntW'(1)) state_d = StPass;
                        end else begin
                            state_d    = StFail;
                            err_d      = ErrMismatch;
                            obs_reg_d  = bus.wb_reg;
                            obs_data_d = bus.wb_data;
                        end
                    end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
                        state_d = StFail;
                        err_d   = ErrTimeout;
                    end else begin
                        timer_d = timer_q + TimerW'(1);
                    end
                end
                StPass, StFail: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            match_q    <= '0;
            err_q      <= ErrNone;
            obs_reg_q  <= '0;
            obs_data_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            match_q    <= match_d;
            err_q      <= err_d;
            obs_reg_q  <= obs_reg_d;
            obs_data_q <= obs_data_d;
        end
    end

    // Status is a pure decode of registered state, so it changes only on clock or reset.
    assign bus.exp_ready   = (state_q == StIdle) && !full;
    assign bus.busy        = (state_q == StArmed);
    assign bus.done        = (state_q == StPass) || (state_q == StFail);
    assign bus.pass        = (state_q == StPass);
    assign bus.fail        = (state_q == StFail);
    assign bus.err_code    = err_q;
    assign bus.match_count = match_q;
    assign bus.obs_reg     = obs_reg_q;
    assign bus.obs_data    = obs_data_q;

endmodule

// File: tb/tb_rf_write_checker.sv
// Directed bench for rf_write_checker: two instances (x0 skipped / not skipped) share stimulus.
module tb_rf_write_checker;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        start;
    logic        exp_valid;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_errors = 0;

    rf_write_checker_if #(.XLEN(32), .REG_W(5), .DEPTH(8)) if_a ();
    rf_write_checker_if #(.XLEN(32), .REG_W(5), .DEPTH(8)) if_b ();

    assign if_a.exp_valid = exp_valid;
    assign if_a.exp_reg   = exp_reg;
    assign if_a.exp_data  = exp_data;
    assign if_a.wb_en     = wb_en;
    assign if_a.wb_reg    = wb_reg;
    assign if_a.wb_data   = wb_data;
    assign if_b.exp_valid = exp_valid;
    assign if_b.exp_reg   = exp_reg;
    assign if_b.exp_data  = exp_data;
    assign if_b.wb_en     = wb_en;
    assign if_b.wb_reg    = wb_reg;
    assign if_b.wb_data   = wb_data;

    rf_write_checker #(
        .XLEN(32), .REG_W(5), .DEPTH(8), .TIMEOUT(16), .SKIP_X0(1)
    ) dut_a (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (clr),
        .start_i (start),
        .bus     (if_a)
    );

    rf_write_checker #(
        .XLEN(32), .REG_W(5), .DEPTH(8), .TIMEOUT(16), .SKIP_X0(0)
    ) dut_b (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (clr),
        .start_i (start),
        .bus     (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        exp_valid = 1'b1;
        exp_reg   = r;
        exp_data  = d;
        step();
        exp_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_reg  = r;
        wb_data = d;
        step();
        wb_en = 1'b0;
    endtask

    task automatic arm();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic flush();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; start = 1'b0;
        exp_valid = 1'b0; exp_reg = '0; exp_data = '0;
        wb_en = 1'b0; wb_reg = '0; wb_data = '0;
        #2;
        check_eq("rst_exp_ready", 32'(if_a.exp_ready), 32'd1);
        check_eq("rst_busy",      32'(if_a.busy), 32'd0);
        check_eq("rst_done",      32'(if_a.done), 32'd0);
        check_eq("rst_match",     32'(if_a.match_count), 32'd0);
        check_eq("rst_err",       32'(if_a.err_code), 32'd0);
        #20;
        rst_n = 1'b1;
        step();

        // 1: single matching write
        push(5'd3, 32'h0000_8008);
        arm();
        check_eq("t1_busy", 32'(if_a.busy), 32'd1);
        wb(5'd3, 32'h0000_8008);
        check_eq("t1_pass",  32'(if_a.pass), 32'd1);
        check_eq("t1_done",  32'(if_a.done), 32'd1);
        check_eq("t1_match", 32'(if_a.match_count), 32'd1);
        check_eq("t1_err",   32'(if_a.err_code), 32'd0);
        flush();

        // 2: data mismatch, then stickiness and clr
        push(5'd3, 32'h0000_8008);
        arm();
        wb(5'd3, 32'h0000_8004);
        check_eq("t2_fail",     32'(if_a.fail), 32'd1);
        check_eq("t2_err",      32'(if_a.err_code), 32'd1);
        check_eq("t2_obs_reg",  32'(if_a.obs_reg), 32'd3);
        check_eq("t2_obs_data", if_a.obs_data, 32'h0000_8004);
        check_eq("t2_match",    32'(if_a.match_count), 32'd0);
        arm();
        check_eq("t2_sticky",   32'(if_a.fail), 32'd1);
        flush();
        check_eq("t2_clr_fail", 32'(if_a.fail), 32'd0);
        check_eq("t2_clr_err",  32'(if_a.err_code), 32'd0);
        check_eq("t2_clr_obs",  if_a.obs_data, 32'd0);
        check_eq("t2_clr_rdy",  32'(if_a.exp_ready), 32'd1);

        // 3: timeout fires 16 cycles after entering ARMED
        push(5'd1, 32'h5);
        arm();
        repeat (15) step();
        check_eq("t3_not_yet", 32'(if_a.fail), 32'd0);
        check_eq("t3_busy",    32'(if_a.busy), 32'd1);
        step();
        check_eq("t3_fail",    32'(if_a.fail), 32'd1);
        check_eq("t3_err",     32'(if_a.err_code), 32'd2);
        flush();

        // 4: x0 write skipped by dut_a, mismatches on dut_b
        push(5'd1, 32'h5);
        arm();
        wb(5'd0, 32'hDEAD_BEEF);
        check_eq("t4a_busy",    32'(if_a.busy), 32'd1);
        check_eq("t4a_match",   32'(if_a.match_count), 32'd0);
        check_eq("t4b_fail",    32'(if_b.fail), 32'd1);
        check_eq("t4b_err",     32'(if_b.err_code), 32'd1);
        check_eq("t4b_obs_reg", 32'(if_b.obs_reg), 32'd0);
        check_eq("t4b_obs_dat", if_b.obs_data, 32'hDEAD_BEEF);
        wb(5'd1, 32'h5);
        check_eq("t4a_pass",    32'(if_a.pass), 32'd1);
        check_eq("t4a_match1",  32'(if_a.match_count), 32'd1);
        flush();

        // 5: fill to DEPTH, dropped 9th push, drain with gaps
        for (int i = 0; i < 8; i++) begin
            check_eq("t5_ready", 32'(if_a.exp_ready), 32'd1);
            push(5'(i + 2), 32'h100 + 32'(i));
        end
        check_eq("t5_full", 32'(if_a.exp_ready), 32'd0);
        push(5'd9, 32'h0000_0BAD);
        check_eq("t5_full2", 32'(if_a.exp_ready), 32'd0);
        arm();
        for (int i = 0; i < 8; i++) begin
            step();
            step();
            check_eq("t5_busy", 32'(if_a.busy), 32'd1);
            wb(5'(i + 2), 32'h100 + 32'(i));
            check_eq("t5_count", 32'(if_a.match_count), 32'(i + 1));
        end
        check_eq("t5_pass",  32'(if_a.pass), 32'd1);
        check_eq("t5_bpass", 32'(if_b.pass), 32'd1);
        flush();

        // 6: async reset mid-run flushes everything
        push(5'd5, 32'h50);
        push(5'd6, 32'h60);
        push(5'd7, 32'h70);
        arm();
        wb(5'd5, 32'h50);
        check_eq("t6_match1", 32'(if_a.match_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_busy",  32'(if_a.busy), 32'd0);
        check_eq("t6_rst_match", 32'(if_a.match_count), 32'd0);
        check_eq("t6_rst_ready", 32'(if_a.exp_ready), 32'd1);
        check_eq("t6_rst_done",  32'(if_a.done), 32'd0);
        rst_n = 1'b1;
        step();
        arm();
        check_eq("t6_empty_pass", 32'(if_a.pass), 32'd1);
        check_eq("t6_match0",     32'(if_a.match_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rf_write_checker.md
Name: rf_write_checker

Overview:
- Parametrised, synthesizable self-check block for CPU instruction tests.
- Holds a queue of DEPTH expected register-file writes (index, data) and compares them in order against the live writeback port (reg_write / write_reg / write_data).
- Reports pass/fail, an error code, and the offending write.
- Replaces single-instruction hard-coded checks (e.g. one AUIPC writeback) with a multi-write, timeout-guarded checker that can be instantiated beside cpu_uart_top.

Parameters:
- XLEN, 32, data width of the register file.
- REG_W, 5, register index width.
- DEPTH, 8, number of expectation entries (power of two, ≥2).
- TIMEOUT, 1024, maximum cycles allowed between accepted writes while armed (≥2).
- SKIP_X0, 1, when 1 ignore writeback events targeting x0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush: return to IDLE and empty the queue.
- start  in  1  arm the checker.
- exp_valid  in  1  expectation push request.
- exp_ready  out  1  expectation slot available.
- exp_reg  in  REG_W  expected destination register.
- exp_data  in  XLEN  expected write data.
- wb_en  in  1  register-file write enable.
- wb_reg  in  REG_W  register-file write index.
- wb_data  in  XLEN  register-file write data.
- busy  out  1  state is ARMED.
- done  out  1  state is PASS or FAIL.
- pass  out  1  all expectations matched.
- fail  out  1  mismatch or timeout.
- err_code  out  2  00 none, 01 mismatch, 10 timeout.
- match_count  out  $clog2(DEPTH+1)  writes matched since start.
- obs_reg  out  REG_W  write index captured at mismatch.
- obs_data  out  XLEN  write data captured at mismatch.

Behaviour:
- Reset (rst=0, async): state IDLE; queue empty; all outputs 0 except exp_ready=1; timeout counter 0.
- States: IDLE, ARMED, PASS, FAIL. All outputs are registered.
- IDLE:
  - exp_ready = !full.
  - A push happens on exp_valid && exp_ready and writes the tail in the same cycle.
  - wb_en is ignored.
  - start with a non-empty queue → ARMED next cycle, with match_count=0 and timer=0.
  - start with an empty queue → PASS next cycle.
- ARMED:
  - exp_ready=0; pushes are dropped.
  - A qualifying event is wb_en=1 and (SKIP_X0=0 or wb_reg≠0).
  - On a qualifying event, compare it with the queue head (index and all XLEN data bits).
  - Match: pop the head, increment match_count, clear the timer. If the queue is now empty → PASS next cycle.
  - Mismatch: go to FAIL with err_code=01. Capture obs_reg/obs_data. match_count is frozen and identifies the failing entry.
  - No qualifying event: timer increments. When timer reaches TIMEOUT-1 → FAIL with err_code=10.
  - A qualifying event on the same cycle as timer expiry takes precedence over the timeout.
- Latency: a writeback in cycle N is reflected in pass/fail/match_count at cycle N+1.
- PASS / FAIL are sticky until clr or rst. start is ignored in these states.
- clr (any state): empty the queue, go to IDLE, clear err_code, obs_* and match_count. clr has priority over start, pushes and writebacks in the same cycle.
- Full queue: exp_ready=0 and no overwrite occurs. The pointers wrap modulo DEPTH.
- rst asserted mid-operation: immediate return to reset values; no partial state is kept.

Decomposition:
- Shared include rf_checker_defs.vh:
  - state encodings (IDLE=0, ARMED=1, PASS=2, FAIL=3);
  - ERR_NONE/ERR_MISMATCH/ERR_TIMEOUT codes.
- Sub-module exp_fifo:
  - synchronous FIFO of width REG_W+XLEN and depth DEPTH, using the same clk/rst;
  - push/pop/flush inputs and full/empty/head outputs;
  - a simultaneous push and pop never occurs here, but must keep the count correct.
- The top level holds the FSM, timer, counters and capture registers.

Test Plan:
1. Push (3, 0x00008008), start; one cycle later drive wb_en=1, wb_reg=3, wb_data=0x00008008 → next cycle pass=1, done=1, match_count=1, err_code=00.
2. Push (3, 0x00008008), start; drive write (3, 0x00008004) → fail=1, err_code=01, obs_reg=3, obs_data=0x00008004, match_count=0.
3. TIMEOUT=16: push (1, 0x5), start, no writes → fail=1 with err_code=10 exactly 16 cycles after ARMED is entered.
4. SKIP_X0=1: push (1, 0x5), start; write (0, 0xDEADBEEF), then (1, 0x5) → pass=1, match_count=1. Repeat with SKIP_X0=0 → fail, err_code=01, obs_reg=0.
5. DEPTH=8: 8 pushes accepted, then exp_ready=0 and a 9th push is dropped. Start, then 8 matching writes with gaps → pass after the 8th, match_count=8.
6. Push 3 entries, start, match 1, then rst=0 asynchronously → all outputs reset immediately. After release, start with no pushes → pass next cycle, proving the queue was flushed.
